// File: rtl/color_pkg.sv
// Shared definitions for the colour-sensor scan controller: sensor pin codes, FSM states
// and the channel-to-filter mapping.
package color_pkg;

  localparam logic [1:0] FILT_RED   = 2'b00;
  localparam logic [1:0] FILT_GREEN = 2'b11;
  localparam logic [1:0] FILT_BLUE  = 2'b01;
  localparam logic [1:0] FILT_CLEAR = 2'b10;

  localparam logic [1:0] RATE_OFF = 2'b00;
  localparam logic [1:0] RATE_20  = 2'b01;

  typedef enum logic [2:0] {IDLE, SETTLE, GATE, STORE, DONE} scan_state_e;

  typedef enum logic [1:0] {CH_R, CH_G, CH_B, CH_C} chan_e;

  function automatic logic [1:0] chan_filter(chan_e ch);
    logic [1:0] code;
    unique case (ch)
      CH_R:    code = FILT_RED;
      CH_G:    code = FILT_GREEN;
      CH_B:    code = FILT_BLUE;
      CH_C:    code = FILT_CLEAR;
      default: code = FILT_RED;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/color_scan_ctrl_if.sv
// Pin and result bundle of the colour scan controller. master = controller side,
// slave = sensor pins plus the downstream white-balance / colour-identify consumer.
interface color_scan_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             frequency;
  logic             start;
  logic             continuous;
  logic [1:0]       filter_out;
  logic [1:0]       frequency_rate;
  logic             busy;
  logic [CNT_W-1:0] red_cnt;
  logic [CNT_W-1:0] green_cnt;
  logic [CNT_W-1:0] blue_cnt;
  logic [CNT_W-1:0] clear_cnt;
  logic             valid;
  logic             overflow;

  modport master (
    input  frequency, start, continuous,
    output filter_out, frequency_rate, busy, red_cnt, green_cnt, blue_cnt, clear_cnt,
           valid, overflow
  );

  modport slave (
    output frequency, start, continuous,
    input  filter_out, frequency_rate, busy, red_cnt, green_cnt, blue_cnt, clear_cnt,
           valid, overflow
  );
endinterface

// File: rtl/color_scan_ctrl_freq_edge_sync.sv
// Brings the asynchronous sensor output into the clk domain (2-FF synchroniser) and
// emits a one-cycle pulse on each synchronised rising edge.
module freq_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic rise_o
);
  logic sync1_q, sync2_q, prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= async_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise_o = sync2_q & ~prev_q;
endmodule

// File: rtl/color_scan_ctrl.sv
// TCS3200-style colour scan sequencer: settle, gate-count and store each filter channel,
// then publish the RGB(C) set with a valid pulse. COLOR_CLEAR_CH_EN adds the clear channel.
module color_scan_ctrl
  import color_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 4000,
  parameter int unsigned GATE_CYC   = 100000,
  parameter int unsigned CNT_W      = 16
) (
  input logic               clk,
  input logic               rst,
  color_scan_ctrl_if.master bus
);

  localparam int unsigned MaxCyc = (SETTLE_CYC > GATE_CYC) ? SETTLE_CYC : GATE_CYC;
  localparam int unsigned TW     = (MaxCyc > 1) ? $clog2(MaxCyc) : 1;
  localparam logic [TW-1:0]    SettleLast = TW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0]    GateLast   = TW'(GATE_CYC - 1);
  localparam logic [CNT_W-1:0] CntMax     = '1;
`ifdef COLOR_CLEAR_CH_EN
  localparam chan_e LastCh = CH_C;
`else
  localparam chan_e LastCh = CH_B;
`endif

  scan_state_e      state_q, state_d;
  logic [TW-1:0]    timer_q;
  logic [CNT_W-1:0] edge_cnt_q;
  logic             ovf_q;
  chan_e            ch_q, ch_next;
  logic [1:0]       filter_q;
  logic [CNT_W-1:0] shadow_r_q, shadow_g_q, shadow_b_q;
  logic [CNT_W-1:0] red_q, green_q, blue_q;
  logic             valid_q, overflow_q;
  logic             freq_rise, settle_last, gate_last;

  freq_edge_sync u_freq_edge_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (bus.frequency),
    .rise_o  (freq_rise)
  );

  assign settle_last = (state_q == SETTLE) && (timer_q == SettleLast);
  assign gate_last   = (state_q == GATE) && (timer_q == GateLast);
  assign ch_next     = chan_e'(ch_q + 2'd1);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start || bus.continuous) state_d = SETTLE;
      SETTLE:  if (settle_last) state_d = GATE;
      GATE:    if (gate_last) state_d = STORE;
      STORE:   state_d = (ch_q == LastCh) ? DONE : SETTLE;
      DONE:    state_d = bus.continuous ? SETTLE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy           = (state_q != IDLE);
    bus.frequency_rate = (state_q == IDLE) ? RATE_OFF : RATE_20;
  end

`ifdef COLOR_CLEAR_CH_EN
  logic [CNT_W-1:0] shadow_c_q, clear_q;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q    <= '0;
      edge_cnt_q <= '0;
      ovf_q      <= 1'b0;
      ch_q       <= CH_R;
      filter_q   <= FILT_RED;
      shadow_r_q <= '0;
      shadow_g_q <= '0;
      shadow_b_q <= '0;
      red_q      <= '0;
      green_q    <= '0;
      blue_q     <= '0;
      valid_q    <= 1'b0;
      overflow_q <= 1'b0;
`ifdef COLOR_CLEAR_CH_EN
      shadow_c_q <= '0;
      clear_q    <= '0;
`endif
    end else begin
      valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (state_d == SETTLE) begin
            ch_q     <= CH_R;
            filter_q <= FILT_RED;
            timer_q  <= '0;
            ovf_q    <= 1'b0;
          end
        end
        SETTLE: begin
          if (settle_last) begin
            timer_q    <= '0;
            edge_cnt_q <= '0;
          end else begin
            timer_q <= timer_q + TW'(1);
          end
        end
        GATE: begin
          timer_q <= gate_last ? '0 : timer_q + TW'(1);
          // Saturate rather than wrap; the scan-level ovf flag records the loss.
          if (freq_rise) begin
            if (edge_cnt_q == CntMax) ovf_q <= 1'b1;
            else                      edge_cnt_q <= edge_cnt_q + CNT_W'(1);
          end
        end
        STORE: begin
          case (ch_q)
            CH_R:    shadow_r_q <= edge_cnt_q;
            CH_G:    shadow_g_q <= edge_cnt_q;
            CH_B:    shadow_b_q <= edge_cnt_q;
            default: begin
`ifdef COLOR_CLEAR_CH_EN
              shadow_c_q <= edge_cnt_q;
`endif
            end
          endcase
          if (ch_q != LastCh) begin
            ch_q     <= ch_next;
            filter_q <= chan_filter(ch_next);
          end
        end
        DONE: begin
          red_q      <= shadow_r_q;
          green_q    <= shadow_g_q;
          blue_q     <= shadow_b_q;
          overflow_q <= ovf_q;
          valid_q    <= 1'b1;
`ifdef COLOR_CLEAR_CH_EN
          clear_q    <= shadow_c_q;
`endif
          if (bus.continuous) begin
            ch_q     <= CH_R;
            filter_q <= FILT_RED;
            timer_q  <= '0;
            ovf_q    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.filter_out = filter_q;
  assign bus.red_cnt    = red_q;
  assign bus.green_cnt  = green_q;
  assign bus.blue_cnt   = blue_q;
  assign bus.valid      = valid_q;
  assign bus.overflow   = overflow_q;
`ifdef COLOR_CLEAR_CH_EN
  assign bus.clear_cnt  = clear_q;
`else
  assign bus.clear_cnt  = '0;
`endif

endmodule
